// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit in front of a
// word-wide data memory with a combinational read port.
// Sub-word stores are done as read-modify-write. Define LSU_MISALIGN_TRAP_EN
// to fault misaligned halfword/word accesses; otherwise misaligned offset
// bits are ignored.
module load_store_unit #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_a_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;   // memory word captured in READ
  logic [31:0] rdata_q, rdata_d; // extended load result held for RESP
  logic        err_q, err_d;

  logic        misalign;
  logic        req_err;

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [1:0]  sz,
                                              input logic        uns,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: load_extend = {{24{b[7] & ~uns}}, b};
      SZ_HALF: load_extend = {{16{h[15] & ~uns}}, h};
      default: load_extend = w;
    endcase
  endfunction

  // Replace only the addressed byte/halfword lane of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [31:0] d,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = w;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0: r[7:0]   = d[7:0];
        2'd1: r[15:8]  = d[7:0];
        2'd2: r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = d[15:0];
    end else begin
      r[15:0] = d[15:0];
    end
    store_merge = r;
  endfunction

  // Fault detection on the incoming request (evaluated at acceptance).
  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
               ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`endif
    req_err = (req_size_i == SZ_ILL) ||
              ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS)) ||
              misalign;
  end

  // Next-state, datapath capture and outputs.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = 32'h0;
    rsp_err_o   = 1'b0;
    mem_a_o     = 32'h0;
    mem_we_o    = 1'b0;
    mem_wd_o    = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          word_d  = 32'h0;
          rdata_d = 32'h0;
          err_d   = req_err;
          if (req_err)                             state_d = RESP;
          else if (req_we_i && req_size_i == SZ_WORD) state_d = WRITE;
          else                                     state_d = READ;
        end
      end
      READ: begin
        mem_a_o = {addr_q[31:2], 2'b00};
        word_d  = mem_rd_i;
        if (we_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = load_extend(mem_rd_i, size_q, uns_q, addr_q[1:0]);
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_a_o  = {addr_q[31:2], 2'b00};
        mem_we_o = 1'b1;
        mem_wd_o = (size_q == SZ_WORD) ? wdata_q
                                       : store_merge(word_q, wdata_q, size_q, addr_q[1:0]);
        state_d  = RESP;
      end
      default: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
        if (rsp_ready_i) state_d = IDLE;
      end
    endcase
  end

  // State and request registers; reset abandons any request in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table through a response scoreboard,
// plus backpressure and mid-write reset sequences.
module tb_load_store_unit;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [DEPTH];
  int          we_cnt = 0;
  logic [31:0] last_wa = 32'h0, last_wd = 32'h0;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    logic [31:0] exp_wa, exp_wd;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we;
    logic [31:0] wa, wd;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .mem_a_o(mem_a), .mem_we_o(mem_we), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, synchronous write.
  assign mem_rd = (mem_a[31:2] < DEPTH) ? mem[mem_a[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_a[31:2] < DEPTH) mem[mem_a[7:2]] <= mem_wd;
      we_cnt  <= we_cnt + 1;
      last_wa <= mem_a;
      last_wd <= mem_wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void add(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee, input int lat,
                              input int ewe, input logic [31:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_we = ewe;
    v.exp_wa = ewa; v.exp_wd = ewd;
    tbl.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    req_we = v.we; req_size = v.size; req_uns = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
  endtask

  // Wait (bounded) for rsp_valid; returns cycles since acceptance.
  task automatic wait_rsp(output int k);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   k, we0;
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    drive(v);
    rsp_ready = 1'b1;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
    e.we = v.exp_we; e.wa = v.exp_wa; e.wd = v.exp_wd;
    sb.push_back(e);
    we0 = we_cnt;
    wait_rsp(k);
    e = sb.pop_front();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
    chk("latency", 32'(k), 32'(e.lat));
    chk("we_pulses", 32'(we_cnt - we0), 32'(e.we));
    if (e.we != 0) begin
      chk("mem_a_write", last_wa, e.wa);
      chk("mem_wd_write", last_wd, e.wd);
    end
  endtask

  initial begin
    int   k, we0;
    vec_t v;

    // we  sz  uns addr          wdata          rdata          err lat we wa      wd
    add(1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0, 2, 1, 32'h10, 32'hDEADBEEF);
    add(0, 2'b10, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0,  32'h0);
    add(1, 2'b10, 0, 32'h20,       32'h11223344, 32'h0,        0, 2, 1, 32'h20, 32'h11223344);
    add(1, 2'b00, 0, 32'h22,       32'h123456AA, 32'h0,        0, 3, 1, 32'h20, 32'h11AA3344);
    add(0, 2'b10, 0, 32'h20,       32'h0,        32'h11AA3344, 0, 2, 0, 32'h0,  32'h0);
    add(1, 2'b10, 0, 32'h0,        32'h8000FF80, 32'h0,        0, 2, 1, 32'h0,  32'h8000FF80);
    add(0, 2'b00, 0, 32'h0,        32'h0,        32'hFFFFFF80, 0, 2, 0, 32'h0,  32'h0);
    add(0, 2'b00, 1, 32'h0,        32'h0,        32'h00000080, 0, 2, 0, 32'h0,  32'h0);
    add(0, 2'b01, 0, 32'h2,        32'h0,        32'hFFFF8000, 0, 2, 0, 32'h0,  32'h0);
    add(0, 2'b01, 1, 32'h2,        32'h0,        32'h00008000, 0, 2, 0, 32'h0,  32'h0);
    add(0, 2'b00, 0, 32'h1,        32'h0,        32'hFFFFFFFF, 0, 2, 0, 32'h0,  32'h0);
    add(0, 2'b00, 1, 32'h3,        32'h0,        32'h00000080, 0, 2, 0, 32'h0,  32'h0);
    add(0, 2'b10, 0, 32'h100,      32'h0,        32'h0,        1, 1, 0, 32'h0,  32'h0);
    add(0, 2'b11, 0, 32'h0,        32'h0,        32'h0,        1, 1, 0, 32'h0,  32'h0);
    add(1, 2'b11, 0, 32'h4,        32'h77777777, 32'h0,        1, 1, 0, 32'h0,  32'h0);
    add(1, 2'b00, 0, 32'h80000000, 32'h55,       32'h0,        1, 1, 0, 32'h0,  32'h0);
    add(1, 2'b10, 0, 32'hFC,       32'hCAFEF00D, 32'h0,        0, 2, 1, 32'hFC, 32'hCAFEF00D);
    add(0, 2'b10, 0, 32'hFC,       32'h0,        32'hCAFEF00D, 0, 2, 0, 32'h0,  32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    add(0, 2'b01, 0, 32'h1,        32'h0,        32'h0,        1, 1, 0, 32'h0,  32'h0);
    add(0, 2'b10, 0, 32'h12,       32'h0,        32'h0,        1, 1, 0, 32'h0,  32'h0);
    add(1, 2'b01, 0, 32'h23,       32'h0000BEEF, 32'h0,        1, 1, 0, 32'h0,  32'h0);
    add(0, 2'b10, 0, 32'h20,       32'h0,        32'h11AA3344, 0, 2, 0, 32'h0,  32'h0);
`else
    add(0, 2'b01, 0, 32'h1,        32'h0,        32'hFFFFFF80, 0, 2, 0, 32'h0,  32'h0);
    add(0, 2'b10, 0, 32'h12,       32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0,  32'h0);
    add(1, 2'b01, 0, 32'h23,       32'h0000BEEF, 32'h0,        0, 3, 1, 32'h20, 32'hBEEF3344);
    add(0, 2'b10, 0, 32'h20,       32'h0,        32'hBEEF3344, 0, 2, 0, 32'h0,  32'h0);
`endif

    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_uns = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Backpressure: response held stable, no new request taken.
    @(negedge clk);
    v = tbl[1];                       // load word @0x10 -> DEADBEEF
    drive(v);
    rsp_ready = 1'b0;
    we0 = we_cnt;
    wait_rsp(k);
    chk("bp_latency", 32'(k), 32'd2);
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1;                 // competing request must be refused
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_rsp_err", 32'(rsp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_no_write", 32'(we_cnt - we0), 32'd0);

    // Reset while in WRITE: write abandoned, no response.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_uns = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55555555; req_valid = 1'b1;
    we0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_in_write", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_we_drop", 32'(mem_we), 32'd0);
    chk("rw_mem_a", mem_a, 32'h0);
    chk("rw_mem_wd", mem_wd, 32'h0);
    chk("rw_req_ready", 32'(req_ready), 32'd1);
    chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rw_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("rw_no_write", 32'(we_cnt - we0), 32'd0);
    run_vec(tbl[1]);                  // word at 0x10 still DEADBEEF

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit words in the attached data memory; word index >= DEPTH_WORDS is out of range.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  in  1  core request valid.
REQ-005 req_ready_o  out  1  unit can accept a request.
REQ-006 req_we_i  in  1  1 = store, 0 = load.
REQ-007 req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr_i  in  32  byte address.
REQ-010 req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid_o  out  1  response valid.
REQ-012 rsp_ready_i  in  1  core accepts response.
REQ-013 rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err_o  out  1  request faulted; no memory write occurred.
REQ-015 mem_a_o  out  32  word-aligned byte address to data memory ([1:0] always 00).
REQ-016 mem_we_o  out  1  data memory write enable.
REQ-017 mem_wd_o  out  32  data memory write data.
REQ-018 mem_rd_i  in  32  data memory combinational read data for mem_a_o.

Function
REQ-019 FSM states IDLE, READ, WRITE, RESP; req_ready_o = 1 only in IDLE.
REQ-020 Handshake: request accepted on a cycle with req_valid_i & req_ready_o; all request fields are registered at acceptance; response completes on rsp_valid_o & rsp_ready_i.
REQ-021 IDLE, accepted request: error -> RESP; word store -> WRITE; load or sub-word store -> READ.
REQ-022 Error conditions: req_size_i = 11, or word index req_addr_i[31:2] >= DEPTH_WORDS, or misalignment (see REQ-033).
REQ-023 READ (one cycle): mem_a_o = {addr[31:2],2'b00}; mem_rd_i captured; load -> RESP, sub-word store -> WRITE.
REQ-024 WRITE (one cycle): mem_we_o = 1, mem_wd_o = word store data or the captured word with the addressed lanes replaced; -> RESP.
REQ-025 mem_we_o SHALL be 1 only in WRITE; it is exactly one cycle per store, never for a load or an error.
REQ-026 Lanes little-endian: byte lane = addr[1:0]; halfword lane = addr[1]; merge replaces only those bytes.
REQ-027 Load extension: byte/half sign-extended from bit 7/15 unless unsigned; word passed unchanged.
REQ-028 RESP: rsp_valid_o = 1, rsp_rdata_o/rsp_err_o stable until rsp_ready_i; then -> IDLE; next request accepted the cycle after.
REQ-029 Latency from acceptance cycle N: error rsp at N+1; load and word store at N+2; sub-word store at N+3 (rsp_ready_i held high).
REQ-030 rsp_valid_o held while rsp_ready_i = 0 for any number of cycles; no new request accepted meanwhile.

Reset
REQ-031 rst_ni low: state IDLE, req_ready_o 1, rsp_valid_o 0, rsp_err_o 0, rsp_rdata_o 0, mem_we_o 0, mem_a_o 0, mem_wd_o 0, asynchronously.
REQ-032 Reset mid-operation (READ/WRITE/RESP) abandons the request with no response and no write; released into IDLE.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=00 is an error.
REQ-034 LSU_MISALIGN_TRAP_EN undefined: no misalignment error; halfword uses addr[1] only, word ignores addr[1:0].

Verification
REQ-035 Store word 0xDEADBEEF @0x10, then load word @0x10 -> one mem_we_o pulse, mem_a_o=0x10, load rsp 0xDEADBEEF at N+2.
REQ-036 Mem word 0x11223344 @0x20; store byte 0xAA @0x22 -> mem_wd_o=0x11AA3344 at N+2, rsp at N+3, err 0.
REQ-037 Mem word 0x8000FF80 @0x0: signed byte @0x0 -> 0xFFFFFF80; unsigned byte -> 0x00000080; signed half @0x2 -> 0xFFFF8000.
REQ-038 Load @0x100 (index 64, DEPTH_WORDS=64) or size 11 -> rsp_err_o=1, rdata 0, no mem_we_o, rsp at N+1; halfword @0x1 -> err 1 only with LSU_MISALIGN_TRAP_EN.
REQ-039 rsp_ready_i low 5 cycles -> rsp_valid_o and data stable, req_ready_o 0; rst_ni pulsed during WRITE -> mem_we_o drops immediately, memory word unchanged.
